reg_writeback: RTL
==================

# reg_writeback

Writeback collector that sits between the execute/retire stages and the `reg_sync` register file, driving its four write ports and its PC and CPSR update ports. Retired results arrive one per cycle over a valid/ready handshake and are buffered in order in a circular FIFO. Each cycle the block drains up to four conflict-free entries into registered write-port outputs. It also exports a pending-write scoreboard that decode uses for RAW stalls.

## Interface
Parameters:
- `N`, 32, data width; matches `reg_sync`.
- `DEPTH`, 8, FIFO entries; power of two, at least 4.

Ports:
- `clk`  in  1  clock; all state updates on the posedge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the posedge.
- `req_valid`  in  1  retire stage presents a result.
- `req_ready`  out  1  entry accepted on a posedge where `req_valid && req_ready`.
- `req_addr`  in  4  destination register; 15 = PC.
- `req_data`  in  N  result value.
- `req_is_cspr`  in  1  entry targets CPSR; `req_addr` is ignored.
- `hold`  in  1  freeze draining; acceptance continues.
- `write_address_1..4`  out  4 each  register-file write addresses.
- `write_data_1..4`  out  N each  register-file write data.
- `write_enable_1..4`  out  1 each  register-file write enables.
- `pc_write`, `pc_update`  out  1, N  PC port.
- `cspr_write`, `cspr_update`  out  1, N  CPSR port.
- `busy_mask`  out  16  bit i set means a write to R[i] is pending.
- `cspr_busy`  out  1  a CPSR write is pending.
- `count`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Entry fields: `{is_cspr, addr[3:0], data[N-1:0]}`. Head and tail pointers are $clog2(DEPTH)+1 bits wide and wrap modulo 2·DEPTH. Occupancy is `tail - head`.
- `req_ready = (count < DEPTH)`, computed from registered state only. There is no same-cycle credit from a pop, so a full FIFO refuses a push even on a cycle where it pops.
- Group selection runs every posedge unless `hold=1` or `count=0`. It scans entries head+0 up to head+min(count,4)-1 in order and stops before the first entry that meets any of these:
  - it is a register entry whose address already appears in the group;
  - it is a CPSR entry and a CPSR entry is already in the group;
  - it is a PC entry and a PC entry is already in the group.
- After the scan, an entry with address 15 terminates the group. That entry is included; nothing after it is.
- Mapping to outputs:
  - The k-th non-PC, non-CPSR entry in the group goes to write port k+1, in FIFO order.
  - A PC entry drives `pc_write`/`pc_update` and uses no numbered port.
  - A CPSR entry drives `cspr_write`/`cspr_update`.
- Group size G is 1 to 4. `head` advances by G.
- All write-port, PC and CPSR outputs are registered. Enables are high for exactly one cycle per drained entry and low on any cycle where nothing is drained. Address and data outputs hold their last value while the enable is low.
- `busy_mask[i]` is the OR of two sources: FIFO entries with `addr==i && !is_cspr`, and the currently asserted output enables targeting R[i]. PC output counts as bit 15. `cspr_busy` is formed the same way for CPSR.
- Reset (`rst_n=0` at a posedge):
  - `head=tail=0`.
  - All enables, `pc_write` and `cspr_write` go to 0.
  - Address and data outputs go to 0.
  - `busy_mask=0`, `cspr_busy=0`.
  - Queued entries are discarded. This also applies to a reset that lands mid-drain.

## Timing
- Push-to-drive latency: an entry accepted at posedge t can appear on the outputs from posedge t+1 at the earliest. `reg_sync` samples it at the following negedge.
- Push and pop in the same cycle are allowed when not full. `count` updates as `count + push - G`.
- `hold` is sampled at the posedge. With `hold=1`, the outputs deassert their enables that same edge.
- `busy_mask` and `cspr_busy` are combinational from registered state and are stable for the whole cycle.

## Structure
- Package `reg_wb_pkg` contains:
  - entry struct `reg_wb_entry_t`;
  - `PC_ADDR = 4'd15`;
  - `NUM_WR_PORTS = 4`.
- Sub-module `reg_wb_fifo`: circular buffer with one push port, combinational read of the head+0 to head+3 slots, a variable pop count of 0 to 4, and a `count` output.
- Top level contains the group-selection logic, the output registers and the scoreboard.

## Test plan
- Push one entry R3=0x11 → one cycle later `write_enable_1=1`, `write_address_1=3`, `write_data_1=0x11`, other enables 0. `busy_mask[3]` is high for 2 cycles, then low.
- Push R1, R2, R4, R5 on consecutive cycles with `hold=1`, then release `hold` → a single cycle shows ports 1–4 = R1, R2, R4, R5; `count` goes 4→0.
- Queue R2=0xA, R2=0xB → cycle 1 writes R2=0xA on port 1 only, cycle 2 writes R2=0xB. The register file never sees both in one cycle.
- Queue R1, R15=0x100, R6 → cycle 1: port 1 = R1, `pc_write=1`, `pc_update=0x100`. Cycle 2: port 1 = R6.
- Hold `req_valid=1` with `hold=1` → `req_ready` drops after 8 accepts with `count=8`. Release `hold` → the head group drains and `req_ready` returns the next cycle.
- Assert `rst_n=0` for one edge while 5 entries are queued and enables are high → the next cycle shows all enables 0, `count=0`, `busy_mask=0`, `req_ready=1`.

Source files
------------

// File: rtl/reg_wb_pkg.sv
// Shared types for the writeback collector: FIFO entry layout and port constants.
package reg_wb_pkg;
  localparam int       WB_DATA_W    = 32;
  localparam int       NUM_WR_PORTS = 4;
  localparam logic [3:0] PC_ADDR    = 4'd15;

  typedef struct packed {
    logic                 is_cspr;
    logic [3:0]           addr;
    logic [WB_DATA_W-1:0] data;
  } reg_wb_entry_t;
endpackage

// File: rtl/reg_writeback_if.sv
// Retire-to-writeback valid/ready request bus.
interface reg_writeback_if #(parameter int N = 32);
  logic         req_valid;
  logic         req_ready;
  logic [3:0]   req_addr;
  logic [N-1:0] req_data;
  logic         req_is_cspr;

  modport master (output req_valid, req_addr, req_data, req_is_cspr, input req_ready);
  modport slave  (input req_valid, req_addr, req_data, req_is_cspr, output req_ready);
endinterface

// File: rtl/reg_wb_fifo.sv
// Circular entry buffer: one push, four-wide head window, pop of 0..4 per cycle.
module reg_wb_fifo
  import reg_wb_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  push,
  input  reg_wb_entry_t                         push_data,
  input  logic [2:0]                            pop,
  output reg_wb_entry_t [NUM_WR_PORTS-1:0]      rd,
  output reg_wb_entry_t [DEPTH-1:0]             slots,
  output logic [DEPTH-1:0]                      slot_vld,
  output logic [AW:0]                           count
);
  reg_wb_entry_t [DEPTH-1:0] mem;
  logic [AW:0] head, tail;

  assign count = tail - head;
  assign slots = mem;

  always_comb begin
    for (int k = 0; k < NUM_WR_PORTS; k++)
      rd[k] = mem[head[AW-1:0] + AW'(k)];
    // a slot is live when its distance from head is below occupancy
    for (int i = 0; i < DEPTH; i++)
      slot_vld[i] = {1'b0, AW'(i) - head[AW-1:0]} < count;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
    end else begin
      head <= head + (AW+1)'(pop);
      if (push) tail <= tail + 1'b1;
    end
  end

  always_ff @(posedge clk)
    if (push) mem[tail[AW-1:0]] <= push_data;
endmodule

// File: rtl/reg_writeback.sv
// Writeback collector: drains up to four conflict-free retired results per cycle into reg_sync.
module reg_writeback
  import reg_wb_pkg::*;
#(
  parameter int N     = WB_DATA_W,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  reg_writeback_if.slave         req,
  input  logic                   hold,
  output logic [3:0]             write_address_1, write_address_2, write_address_3, write_address_4,
  output logic [N-1:0]           write_data_1, write_data_2, write_data_3, write_data_4,
  output logic                   write_enable_1, write_enable_2, write_enable_3, write_enable_4,
  output logic                   pc_write,
  output logic [N-1:0]           pc_update,
  output logic                   cspr_write,
  output logic [N-1:0]           cspr_update,
  output logic [15:0]            busy_mask,
  output logic                   cspr_busy,
  output logic [$clog2(DEPTH):0] count
);
  reg_wb_entry_t                      push_e;
  reg_wb_entry_t [NUM_WR_PORTS-1:0]   rd;
  reg_wb_entry_t [DEPTH-1:0]          slots;
  logic [DEPTH-1:0]                   slot_vld;
  logic                               push;
  logic [2:0]                         pop;

  logic [NUM_WR_PORTS-1:0]            sel_we, we_q;
  logic [NUM_WR_PORTS-1:0][3:0]       sel_wa, wa_q;
  logic [NUM_WR_PORTS-1:0][N-1:0]     sel_wd, wd_q;
  logic                               sel_pc, sel_cspr;
  logic [N-1:0]                       sel_pc_d, sel_cspr_d;

  // no same-cycle credit from a pop: ready looks at registered occupancy only
  assign req.req_ready = (count < ($clog2(DEPTH)+1)'(DEPTH));
  assign push          = req.req_valid && req.req_ready;
  assign push_e        = '{is_cspr: req.req_is_cspr, addr: req.req_addr, data: req.req_data};

  reg_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .push_data(push_e), .pop(pop),
    .rd(rd), .slots(slots), .slot_vld(slot_vld), .count(count)
  );

  always_comb begin
    logic [15:0]   used;
    logic          stop;
    logic [1:0]    np;
    int            avail;
    reg_wb_entry_t e;
    sel_we = '0; sel_wa = '0; sel_wd = '0;
    sel_pc = 1'b0; sel_pc_d = '0; sel_cspr = 1'b0; sel_cspr_d = '0;
    pop = '0; used = '0; stop = 1'b0; np = '0; e = '0;
    avail = hold ? 0 : ((int'(count) > NUM_WR_PORTS) ? NUM_WR_PORTS : int'(count));
    for (int k = 0; k < NUM_WR_PORTS; k++) begin
      if (k < avail && !stop) begin
        e = rd[k];
        if (e.is_cspr) begin
          if (sel_cspr) stop = 1'b1;
          else begin
            sel_cspr = 1'b1; sel_cspr_d = e.data; pop = pop + 3'd1;
          end
        end else if (e.addr == PC_ADDR) begin
          // a PC write closes the group; later entries may depend on the branch
          sel_pc = 1'b1; sel_pc_d = e.data; pop = pop + 3'd1; stop = 1'b1;
        end else if (used[e.addr]) begin
          stop = 1'b1;
        end else begin
          used[e.addr] = 1'b1;
          sel_we[np] = 1'b1; sel_wa[np] = e.addr; sel_wd[np] = e.data;
          np = np + 2'd1; pop = pop + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q <= '0; wa_q <= '0; wd_q <= '0;
      pc_write <= 1'b0; pc_update <= '0;
      cspr_write <= 1'b0; cspr_update <= '0;
    end else begin
      we_q       <= sel_we;
      pc_write   <= sel_pc;
      cspr_write <= sel_cspr;
      if (sel_pc)   pc_update   <= sel_pc_d;
      if (sel_cspr) cspr_update <= sel_cspr_d;
      for (int k = 0; k < NUM_WR_PORTS; k++)
        if (sel_we[k]) begin
          wa_q[k] <= sel_wa[k];
          wd_q[k] <= sel_wd[k];
        end
    end
  end

  always_comb begin
    busy_mask = '0;
    cspr_busy = cspr_write;
    for (int i = 0; i < DEPTH; i++)
      if (slot_vld[i]) begin
        if (slots[i].is_cspr) cspr_busy = 1'b1;
        else                  busy_mask[slots[i].addr] = 1'b1;
      end
    for (int k = 0; k < NUM_WR_PORTS; k++)
      if (we_q[k]) busy_mask[wa_q[k]] = 1'b1;
    if (pc_write) busy_mask[PC_ADDR] = 1'b1;
  end

  assign {write_enable_4, write_enable_3, write_enable_2, write_enable_1} = we_q;
  assign write_address_1 = wa_q[0]; assign write_data_1 = wd_q[0];
  assign write_address_2 = wa_q[1]; assign write_data_2 = wd_q[1];
  assign write_address_3 = wa_q[2]; assign write_data_3 = wd_q[2];
  assign write_address_4 = wa_q[3]; assign write_data_4 = wd_q[3];
endmodule
